// File: rtl/bch_correct_buffer_pkg.sv
// rtl/bch_correct_buffer_pkg.sv - shared sizing helpers and read FSM encodings for the BCH correction buffer
// Purpose : WORDS helper, buffer address width, frame-count width and the
//           legacy-style read FSM state constants used by bch_correct_buffer.
// Ports   : none (package).
package bch_correct_buffer_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_READ = 1'b1;

   // Beats per codeword data portion: ceil(data_bits / bits).
   function automatic int words_f(input int data_bits, input int bits);
      return (data_bits + bits - 1) / bits;
   endfunction

   // Buffer address width, clog2(frames*words), never narrower than one bit.
   function automatic int addr_w_f(input int frames, input int words);
      return (frames * words > 1) ? $clog2(frames * words) : 1;
   endfunction

   // Width of the committed-frame counter, clog2(frames+1).
   function automatic int cnt_w_f(input int frames);
      return $clog2(frames + 1);
   endfunction

   // Width of a beat index within one frame, never narrower than one bit.
   function automatic int idx_w_f(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/bch_correct_buffer_ram.sv
// rtl/bch_correct_buffer_ram.sv - simple dual-port RAM with synchronous read (module bch_buffer_ram)
// Purpose : frame storage for bch_correct_buffer; one write port, one
//           registered read port. Read-during-write to the same address
//           returns the old contents.
// Ports   : clk            clock
//           we/waddr/wdata write port
//           raddr          read address, sampled on clk
//           rdata          registered read data
module bch_buffer_ram #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 10,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/bch_correct_buffer.sv
// rtl/bch_correct_buffer.sv - buffers codeword data beats and XORs in the error-locator stream
// Purpose : holds up to FRAMES data frames of WORDS beats while the decoder
//           runs, then emits each frame corrected by the err mask stream.
// Ports   : clk, reset (async, active-high)
//           start, ce, data_in     write side, beat 0 flagged by start
//           first, err             error stream for the oldest frame
//           data_out, valid_out,
//           first_out              corrected beats, one cycle after err
//           overflow, underflow    sticky error flags
//           err_bits               popcount of the frame's err mask, present
//                                  only when BCH_CORRECT_COUNT_EN is defined
module bch_correct_buffer
   import bch_correct_buffer_pkg::*;
#(
   parameter int DATA_BITS = 5,
   parameter int BITS      = 1,
   parameter int FRAMES    = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            ce,
   input  logic [BITS-1:0] data_in,
   input  logic            first,
   input  logic [BITS-1:0] err,
   output logic [BITS-1:0] data_out,
   output logic            valid_out,
   output logic            first_out,
`ifdef BCH_CORRECT_COUNT_EN
   output logic [$clog2(DATA_BITS+1)-1:0] err_bits,
`endif
   output logic            overflow,
   output logic            underflow
);

   localparam int WORDS = words_f(DATA_BITS, BITS);
   localparam int DEPTH = FRAMES * WORDS;
   localparam int AW    = addr_w_f(FRAMES, WORDS);
   localparam int CW    = cnt_w_f(FRAMES);
   localparam int IW    = idx_w_f(WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   // Circular add; operands never exceed two buffer lengths.
   function automatic logic [AW-1:0] addr_add(input logic [AW-1:0] a, input int n);
      int s;
      s = int'(a) + n;
      if (s >= DEPTH) s = s - DEPTH;
      return AW'(s);
   endfunction

   logic          wr_active_q, wr_active_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [AW-1:0] wr_base_q, wr_base_d;
   logic          commit_q, commit_d;
   logic [CW-1:0] count_q, count_d;
   logic [0:0]    state_q, state_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;
   logic [AW-1:0] rd_base_q, rd_base_d;
   logic [BITS-1:0] head0_q, head0_d;
   logic [BITS-1:0] data_out_q, data_out_d;
   logic          valid_out_q, valid_out_d;
   logic          first_out_q, first_out_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic          release_beat;
   logic [CW:0]   held;
   logic          ram_we;
   logic [AW-1:0] ram_waddr, ram_raddr;
   logic [BITS-1:0] ram_rdata;

   bch_buffer_ram #(.WIDTH(BITS), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(ram_waddr),
      .wdata(data_in),
      .raddr(ram_raddr),
      .rdata(ram_rdata)
   );

   // A frame whose commit is still in flight already occupies its slot.
   assign held = {1'b0, count_q} + (CW+1)'(commit_q);

   always_comb begin
      wr_active_d = wr_active_q;
      wr_idx_d    = wr_idx_q;
      wr_base_d   = wr_base_q;
      commit_d    = 1'b0;
      overflow_d  = overflow_q;
      ram_we      = 1'b0;
      ram_waddr   = wr_base_q;
      if (ce && start) begin
         if (held >= (CW+1)'(FRAMES)) begin
            overflow_d  = 1'b1;
            wr_active_d = 1'b0;
         end else begin
            // Also covers a restart mid-frame: the base has not moved yet.
            ram_we = 1'b1;
            if (WORDS == 1) begin
               commit_d    = 1'b1;
               wr_active_d = 1'b0;
               wr_base_d   = addr_add(wr_base_q, WORDS);
            end else begin
               wr_active_d = 1'b1;
               wr_idx_d    = IW'(1);
            end
         end
      end else if (ce && wr_active_q) begin
         ram_we    = 1'b1;
         ram_waddr = addr_add(wr_base_q, int'(wr_idx_q));
         if (wr_idx_q == LAST_IDX) begin
            commit_d    = 1'b1;
            wr_active_d = 1'b0;
            wr_base_d   = addr_add(wr_base_q, WORDS);
         end else begin
            wr_idx_d = wr_idx_q + IW'(1);
         end
      end
   end

   // The RAM address is always one beat ahead of the beat being emitted, so
   // word 0 of the oldest frame sits on ram_rdata while idle. head0 keeps a
   // copy of that word for a restart while already reading.
   always_comb begin
      state_d      = state_q;
      rd_idx_d     = rd_idx_q;
      rd_base_d    = rd_base_q;
      head0_d      = head0_q;
      data_out_d   = '0;
      valid_out_d  = 1'b0;
      first_out_d  = 1'b0;
      underflow_d  = underflow_q;
      release_beat = 1'b0;
      ram_raddr    = rd_base_q;
      case (state_q)
         ST_IDLE: begin
            head0_d = ram_rdata;
            if (first) begin
               if (count_q == '0) begin
                  underflow_d = 1'b1;
               end else begin
                  data_out_d  = ram_rdata ^ err;
                  valid_out_d = 1'b1;
                  first_out_d = 1'b1;
                  ram_raddr   = addr_add(rd_base_q, 1);
                  if (WORDS == 1) begin
                     release_beat = 1'b1;
                     rd_base_d    = addr_add(rd_base_q, WORDS);
                  end else begin
                     state_d  = ST_READ;
                     rd_idx_d = IW'(1);
                  end
               end
            end
         end
         default: begin
            valid_out_d = 1'b1;
            if (first) begin
               data_out_d  = head0_q ^ err;
               first_out_d = 1'b1;
               rd_idx_d    = IW'(1);
               ram_raddr   = addr_add(rd_base_q, 1);
            end else begin
               data_out_d = ram_rdata ^ err;
               if (rd_idx_q == LAST_IDX) begin
                  release_beat = 1'b1;
                  state_d      = ST_IDLE;
                  rd_idx_d     = '0;
                  rd_base_d    = addr_add(rd_base_q, WORDS);
                  ram_raddr    = addr_add(rd_base_q, WORDS);
               end else begin
                  rd_idx_d  = rd_idx_q + IW'(1);
                  ram_raddr = addr_add(rd_base_q, int'(rd_idx_q) + 1);
               end
            end
         end
      endcase
   end

   assign count_d = count_q + CW'(commit_q) - CW'(release_beat);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_active_q <= 1'b0;
         wr_idx_q    <= '0;
         wr_base_q   <= '0;
         commit_q    <= 1'b0;
         count_q     <= '0;
         state_q     <= ST_IDLE;
         rd_idx_q    <= '0;
         rd_base_q   <= '0;
         head0_q     <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
         first_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_active_q <= wr_active_d;
         wr_idx_q    <= wr_idx_d;
         wr_base_q   <= wr_base_d;
         commit_q    <= commit_d;
         count_q     <= count_d;
         state_q     <= state_d;
         rd_idx_q    <= rd_idx_d;
         rd_base_q   <= rd_base_d;
         head0_q     <= head0_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         first_out_q <= first_out_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;
   assign first_out = first_out_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

`ifdef BCH_CORRECT_COUNT_EN
   localparam int EW  = $clog2(DATA_BITS + 1);
   localparam int PAD = WORDS * BITS - DATA_BITS;
   // Pad bits at the bottom of the final beat are not codeword bits.
   localparam logic [BITS-1:0] LAST_MASK = ~BITS'((1 << PAD) - 1);

   function automatic logic [EW-1:0] popcnt(input logic [BITS-1:0] v);
      logic [EW-1:0] n;
      n = '0;
      for (int i = 0; i < BITS; i++) n = n + EW'(v[i]);
      return n;
   endfunction

   logic [EW-1:0]   acc_q, acc_d, err_bits_q, err_bits_d;
   logic [BITS-1:0] err_masked;

   always_comb begin
      err_masked = release_beat ? (err & LAST_MASK) : err;
      acc_d      = acc_q;
      err_bits_d = err_bits_q;
      if (first_out_d)      acc_d = popcnt(err_masked);
      else if (valid_out_d) acc_d = acc_q + popcnt(err_masked);
      if (release_beat)     err_bits_d = acc_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q      <= '0;
         err_bits_q <= '0;
      end else begin
         acc_q      <= acc_d;
         err_bits_q <= err_bits_d;
      end
   end

   assign err_bits = err_bits_q;
`endif

endmodule

// File: tb/tb_bch_correct_buffer.sv
// tb/tb_bch_correct_buffer.sv - directed self-checking bench for bch_correct_buffer
module tb_bch_correct_buffer;

   logic       clk = 1'b0;
   logic       reset;
   always #5 clk = ~clk;

   // DUT 1: DATA_BITS=5, BITS=1, FRAMES=2
   logic       start, ce, first;
   logic [0:0] data_in, err, data_out;
   logic       valid_out, first_out, overflow, underflow;
   logic [2:0] err_bits;

   // DUT 2: DATA_BITS=5, BITS=2, FRAMES=2 (WORDS=3, one pad bit)
   logic       start2, ce2, first2;
   logic [1:0] data_in2, err2, data_out2;
   logic       valid_out2, first_out2, overflow2, underflow2;
   logic [2:0] err_bits2;

   bch_correct_buffer #(.DATA_BITS(5), .BITS(1), .FRAMES(2)) dut (
      .clk(clk), .reset(reset), .start(start), .ce(ce), .data_in(data_in),
      .first(first), .err(err), .data_out(data_out), .valid_out(valid_out),
      .first_out(first_out),
`ifdef BCH_CORRECT_COUNT_EN
      .err_bits(err_bits),
`endif
      .overflow(overflow), .underflow(underflow)
   );

   bch_correct_buffer #(.DATA_BITS(5), .BITS(2), .FRAMES(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .ce(ce2), .data_in(data_in2),
      .first(first2), .err(err2), .data_out(data_out2), .valid_out(valid_out2),
      .first_out(first_out2),
`ifdef BCH_CORRECT_COUNT_EN
      .err_bits(err_bits2),
`endif
      .overflow(overflow2), .underflow(underflow2)
   );

`ifndef BCH_CORRECT_COUNT_EN
   assign err_bits  = 3'd0;
   assign err_bits2 = 3'd0;
`endif

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int wguard, rguard;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 0; ce = 0; data_in = 0; first = 0; err = 0;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   // MSB-first frame into DUT 1, followed by optional parity beats.
   task automatic send_frame(input logic [4:0] d, input int parity);
      for (int k = 0; k < 5; k++) begin
         start = (k == 0); ce = 1'b1; data_in = d[4-k];
         tick();
      end
      start = 1'b0;
      for (int k = 0; k < parity; k++) begin
         data_in = 1'b1;
         tick();
      end
      ce = 1'b0; data_in = 1'b0;
   endtask

   // Error stream for DUT 1; each beat's output is checked one cycle later.
   task automatic stream(input string tag, input logic [4:0] e, input logic [4:0] exp);
      for (int k = 0; k < 5; k++) begin
         first = (k == 0); err = e[4-k];
         tick();
         chk(tag, 32'({valid_out, first_out, data_out}), 32'({1'b1, (k == 0), exp[4-k]}));
      end
      first = 1'b0; err = 1'b0;
   endtask

   task automatic expect_underflow(input string tag);
      first = 1'b1; err = 1'b0;
      tick();
      first = 1'b0;
      chk(tag, 32'({underflow, valid_out}), 32'(2'b10));
   endtask

   logic [5:0] din2_tab [4];
   logic [5:0] err2_tab [4];

   initial begin
      din2_tab[0] = 6'b101101; err2_tab[0] = 6'b000100;
      din2_tab[1] = 6'b010010; err2_tab[1] = 6'b100001;
      din2_tab[2] = 6'b111000; err2_tab[2] = 6'b011010;
      din2_tab[3] = 6'b001111; err2_tab[3] = 6'b000000;
      start2 = 0; ce2 = 0; data_in2 = 0; first2 = 0; err2 = 0;
      start = 0; ce = 0; data_in = 0; first = 0; err = 0;

      reset = 1'b1;
      tick(); tick();
      chk("reset_outputs", 32'({data_out, valid_out, first_out, overflow, underflow}), 32'd0);
      reset = 1'b0;
      tick();

      // Empty buffer: underflow, no output.
      expect_underflow("underflow_empty");
      tick();
      chk("underflow_sticky", 32'(underflow), 32'd1);
      do_reset();
      chk("underflow_cleared", 32'(underflow), 32'd0);

      // Single frame 10110 corrected by 00100 -> 10010; parity beats ignored.
      send_frame(5'b10110, 3);
      idle(1);
      stream("t1_beat", 5'b00100, 5'b10010);
      tick();
      chk("t1_valid_drop", 32'(valid_out), 32'd0);
      chk("t1_flags", 32'({overflow, underflow}), 32'd0);
`ifdef BCH_CORRECT_COUNT_EN
      send_frame(5'b10110, 0);
      idle(2);
      stream("cnt_beat", 5'b10001, 5'b00111);
      chk("err_bits_last", 32'(err_bits), 32'd2);
      tick();
      chk("err_bits_held", 32'(err_bits), 32'd2);
`endif

      // Two frames back-to-back, third dropped.
      do_reset();
      send_frame(5'b11001, 0);
      send_frame(5'b00111, 0);
      send_frame(5'b11111, 0);
      chk("overflow_set", 32'(overflow), 32'd1);
      idle(2);
      stream("ov_a", 5'b00000, 5'b11001);
      idle(1);
      stream("ov_b", 5'b00000, 5'b00111);
      idle(2);
      expect_underflow("ov_third_dropped");

      // Restart mid-frame: only 01011 is committed.
      do_reset();
      start = 1'b1; ce = 1'b1; data_in = 1'b1; tick();
      start = 1'b0; data_in = 1'b1; tick();
      send_frame(5'b01011, 2);
      idle(2);
      stream("mid_beat", 5'b00000, 5'b01011);
      idle(2);
      expect_underflow("mid_single_frame");

      // Reset while reading discards everything.
      do_reset();
      send_frame(5'b10110, 0);
      idle(2);
      first = 1'b1; err = 1'b0; tick();
      first = 1'b0; tick();
      chk("rst_read_active", 32'(valid_out), 32'd1);
      reset = 1'b1;
      tick();
      chk("rst_read_outputs", 32'({data_out, valid_out, first_out}), 32'd0);
      reset = 1'b0;
      tick();
      expect_underflow("rst_read_count0");

      // DUT 2: four frames through a two-frame buffer with wrap-around.
      do_reset();
      fork
         begin
            for (int j = 0; j < 4; j++) begin
               wguard = 0;
               while ((j - rd_cnt) >= 2 && wguard < 200) begin
                  tick();
                  wguard++;
               end
               if (wguard >= 200) chk("wrap_writer_timeout", 32'd1, 32'd0);
               for (int k = 0; k < 3; k++) begin
                  start2 = (k == 0); ce2 = 1'b1; data_in2 = din2_tab[j][5-2*k -: 2];
                  tick();
               end
               start2 = 1'b0; data_in2 = 2'b11;
               tick();
               ce2 = 1'b0; data_in2 = 2'b00;
               wr_cnt++;
            end
         end
         begin
            for (int i = 0; i < 4; i++) begin
               logic [1:0] e2;
               rguard = 0;
               while (wr_cnt <= i && rguard < 200) begin
                  tick();
                  rguard++;
               end
               if (rguard >= 200) chk("wrap_reader_timeout", 32'd1, 32'd0);
               idle(2);
               for (int k = 0; k < 3; k++) begin
                  first2 = (k == 0); err2 = err2_tab[i][5-2*k -: 2];
                  e2 = din2_tab[i][5-2*k -: 2] ^ err2_tab[i][5-2*k -: 2];
                  tick();
                  chk("wrap_beat", 32'({valid_out2, first_out2, data_out2}), 32'({1'b1, (k == 0), e2}));
               end
               first2 = 1'b0; err2 = 2'b00;
               rd_cnt++;
            end
         end
      join
      chk("wrap_flags", 32'({overflow2, underflow2}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
